// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: LSB-first bit-serial adder with IDLE/SHIFT/DONE handshake.
// Define SERIAL_ADDER_CTRL_SUB_EN to add the sub port (a - b via ~b and carry-in 1).
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_CTRL_SUB_EN
    input  logic             sub,
`endif
    input  logic             ack,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d, cout_q, cout_d;
    logic [WIDTH-1:0] b_in;
    logic             c_in, s, co;
`ifdef SERIAL_ADDER_CTRL_SUB_EN
    assign b_in = sub ? ~b : b;
    assign c_in = sub | cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif
    assign s  = a_q[0] ^ b_q[0] ^ c_q;
    assign co = (c_q & (a_q[0] ^ b_q[0])) | (a_q[0] & b_q[0]);
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: if (start) begin
                a_d     = a;
                b_d     = b_in;
                c_d     = c_in;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                // result bit enters at the MSB so after WIDTH shifts bit 0 sits at LSB
                r_d   = (r_q >> 1) | (WIDTH'(s) << (WIDTH - 1));
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = co;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    sum_d   = r_d;
                    cout_d  = co;
                end
            end
            DONE: state_d = ack ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end
    assign ready = state_q == IDLE;
    assign busy  = state_q == SHIFT || state_q == DONE;
    assign done  = state_q == DONE;
    assign sum   = sum_q;
    assign cout  = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed checks of serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       sub = 1'b0;
    logic       ack = 1'b0;
    logic       ready, busy, done, cout;
    logic [7:0] sum;
    int         checks = 0;
    int         errors = 0;
    int         lat;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_CTRL_SUB_EN
        .sub(sub),
`endif
        .ack(ack), .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // accept one operation, scramble inputs afterwards, count edges until done
    task automatic run(input logic [7:0] xa, input logic [7:0] xb, input logic xc, output int n);
        a = xa; b = xb; cin = xc; start = 1'b1;
        tick();
        start = 1'b0; a = ~xa; b = 8'h55; cin = ~xc;
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        #2;
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick();
        check("idle_ready", ready, 1);

        run(8'h00, 8'h00, 1'b0, lat);
        check("zero_lat", lat, 8);
        check("zero_sum", sum, 8'h00);
        check("zero_cout", cout, 0);
        do_ack();
        check("ack_ready", ready, 1);

        run(8'hFF, 8'h01, 1'b0, lat);
        check("ff01_sum", sum, 8'h00);
        check("ff01_cout", cout, 1);
        do_ack();

        run(8'hA5, 8'h5A, 1'b1, lat);
        check("a55a_sum", sum, 8'h00);
        check("a55a_cout", cout, 1);
        do_ack();

        run(8'h3C, 8'h0F, 1'b0, lat);
        check("3c0f_sum", sum, 8'h4B);
        check("3c0f_cout", cout, 0);
        do_ack();
        check("hold_after_ack", sum, 8'h4B);

        // backpressure and ignored start during SHIFT
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_shift", busy, 1);
        check("hold_in_shift", sum, 8'h4B);
        tick();
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        lat = 3;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        check("bp_lat", lat, 8);
        check("bp_sum", sum, 8'h46);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_done", done, 1);
            check("bp_hold", sum, 8'h46);
        end
        ack = 1'b1; start = 1'b1;
        tick();
        ack = 1'b0; start = 1'b0;
        check("ackstart_ready", ready, 1);
        tick();
        check("no_queue", ready, 1);
        do_ack();
        check("ack_idle_ignored", ready, 1);

        // async reset mid-SHIFT
        a = 8'h7F; b = 8'h01; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #1;
        check("abort_ready", ready, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("abort_no_done", done, 0);
        end
        run(8'h03, 8'h04, 1'b0, lat);
        check("post_lat", lat, 8);
        check("post_sum", sum, 8'h07);
        check("post_cout", cout, 0);
        do_ack();

`ifdef SERIAL_ADDER_CTRL_SUB_EN
        sub = 1'b1;
        run(8'h10, 8'h01, 1'b0, lat);
        check("sub_1001_sum", sum, 8'h0F);
        check("sub_1001_cout", cout, 1);
        do_ack();
        run(8'h01, 8'h02, 1'b0, lat);
        check("sub_0102_sum", sum, 8'hFF);
        check("sub_0102_cout", cout, 0);
        do_ack();
        sub = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
